regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the multicycle CPU datapath.
- Provides NRD asynchronous read ports and two clocked write ports, with register 0 hard-wired to zero.
- Carries a per-register pending-write scoreboard so control logic can stall on operands whose producer has not yet written back.
- Writes are clock-edge only; nothing is level-sensitive to data or address.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NRD, 2, number of read ports (1..4); read ports are flattened buses.
- RESET_VAL, 32'h0000_0001, value loaded into registers 1..depth-1 on reset; must be representable in DATA_W bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- ra  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- rbusy  out  NRD  port k's addressed register has a pending write.
- we0  in  1  write enable, port 0 (ALU writeback).
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (memory writeback).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- bset  in  1  mark register bsa as pending (issue of a producer).
- bsa  in  ADDR_W  scoreboard set address.
- any_busy  out  1  OR of all scoreboard bits.

Behaviour:
- Reset (asynchronous, takes effect immediately while rst=1):
  - reg[0]=0; reg[1..depth-1]=RESET_VAL; all busy bits=0.
  - Outputs follow combinationally: rdata = 0 for address 0, RESET_VAL otherwise; rbusy=0; any_busy=0.
  - rst asserted mid-write: the write is lost and the reset value wins.
- Read:
  - Combinational, zero latency: rdata[k] = reg[ra[k]].
  - Address 0 always reads 0.
  - rbusy[k] = busy[ra[k]], always 0 for address 0.
- Write, on the rising clk edge with rst=0:
  - weN=1 and waN!=0 → reg[waN] <= wdN.
  - Writes to address 0 are ignored.
  - we0 and we1 to the same nonzero address in one cycle: port 1 wins; exactly one write occurs.
  - Different addresses: both writes complete in the same cycle.
- Scoreboard, evaluated per edge for each address a:
  - set = bset && bsa==a && a!=0.
  - clr = (we0 && wa0==a) || (we1 && wa1==a).
  - busy[a] <= set ? 1 : (clr ? 0 : busy[a]).
  - set and clr on the same address in the same cycle: set wins. This models a new producer issued as the old one writes back.
  - bset to address 0 is ignored.
  - A write to a non-busy register leaves its busy bit at 0; this is not an error.
- Read-during-write, with the bypass feature disabled: the read returns the old value until the edge and the new value after it.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - Read ports forward same-cycle write data combinationally. If ra[k]!=0 and matches an enabled write address, rdata[k] = that write's data, with port 1 taking priority over port 0.
  - rbusy[k] is forced to 0 when forwarding occurs.
- Undefined:
  - Reads return stored register contents only.
  - rbusy reflects the stored busy bit only.

Test Plan:
- Release rst, then read all addresses → r0=0x00000000, r1..r31=0x00000001; rbusy=0; any_busy=0.
- we0=1, wa0=5, wd0=0xDEADBEEF for one edge; then ra[0]=5 → rdata[0]=0xDEADBEEF. Separately, we0=1, wa0=0, wd0=0x1234 → r0 still reads 0.
- Same edge: we0=1, wa0=7, wd0=0xAAAA0000 and we1=1, wa1=7, wd1=0x5555FFFF → r7=0x5555FFFF. Repeat with wa1=8 → r7=0xAAAA0000 and r8=0x5555FFFF.
- bset=1, bsa=9, then ra[1]=9 → rbusy[1]=1 and any_busy=1.
  - Next cycle: we1=1, wa1=9 and bset=1, bsa=9 together → busy[9] remains 1.
  - Following write alone → busy[9]=0 and any_busy=0.
- Assert rst asynchronously between edges while we0=1, wa0=3, wd0=0xFFFFFFFF and busy[4]=1 → r3 reads 0x00000001 immediately, busy[4]=0, and no write occurs on the next edge while rst is high.
- With REGFILE_MP_BYPASS_EN: we0=1, wa0=10, wd0=0xCAFEF00D, ra[0]=10, before the edge → rdata[0]=0xCAFEF00D. Without the macro → rdata[0]=0x00000001 before the edge and 0xCAFEF00D after it.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp : multi-port general-purpose register file for the multicycle CPU
//
// - NRD combinational read ports on flattened buses, two clocked write ports
//   (port 0 = ALU writeback, port 1 = memory writeback, port 1 wins on a
//   same-address collision).
// - Register 0 is hard-wired to zero; writes and scoreboard sets to it are
//   ignored.
// - A per-register pending-write scoreboard lets control logic stall on
//   operands whose producer has not written back yet. A set and a clear of
//   the same register on one edge leave it busy, because that is a new
//   producer issuing as the old one retires.
//
// Optional build macro: REGFILE_MP_BYPASS_EN
//   When defined, read ports forward same-cycle write data (port 1 over
//   port 0) and report not-busy while forwarding. Forwarding is suppressed
//   while rst is high so that reset values are visible immediately.
//   When undefined, reads see stored contents and stored busy bits only.
// -----------------------------------------------------------------------------
module regfile_mp #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 5,
   parameter int                NRD       = 2,
   parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(32'h0000_0001)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NRD*ADDR_W-1:0]    ra,
   output logic [NRD*DATA_W-1:0]    rdata,
   output logic [NRD-1:0]           rbusy,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   input  logic                     bset,
   input  logic [ADDR_W-1:0]        bsa,
   output logic                     any_busy
);

   localparam int DEPTH = 1 << ADDR_W;

   // Architectural state and its next-state values
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   // One-hot address decodes, bit 0 is always left clear
   logic [DEPTH-1:0]  wr0_hit;
   logic [DEPTH-1:0]  wr1_hit;
   logic [DEPTH-1:0]  set_hit;

   // Per-read-port working values
   logic [ADDR_W-1:0] rd_addr [NRD];
   logic [DATA_W-1:0] rd_val  [NRD];
   logic              rd_bsy  [NRD];

   // Decode write and scoreboard-set addresses; register 0 never matches
   always_comb begin
      wr0_hit = '0;
      wr1_hit = '0;
      set_hit = '0;
      for (int a = 1; a < DEPTH; a++) begin
         wr0_hit[a] = we0  && (wa0 == ADDR_W'(a));
         wr1_hit[a] = we1  && (wa1 == ADDR_W'(a));
         set_hit[a] = bset && (bsa == ADDR_W'(a));
      end
   end

   // Next register contents: port 1 overrides port 0 on a shared address
   always_comb begin
      for (int a = 0; a < DEPTH; a++) begin
         regs_d[a] = regs_q[a];
         if (wr1_hit[a]) begin
            regs_d[a] = wd1;
         end else if (wr0_hit[a]) begin
            regs_d[a] = wd0;
         end
      end
      regs_d[0] = '0;
   end

   // Next scoreboard state: a new issue beats a retiring writeback
   always_comb begin
      busy_d = busy_q;
      for (int a = 1; a < DEPTH; a++) begin
         if (set_hit[a]) begin
            busy_d[a] = 1'b1;
         end else if (wr0_hit[a] || wr1_hit[a]) begin
            busy_d[a] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   // State registers with asynchronous reset to the power-on contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q[0] <= '0;
         for (int a = 1; a < DEPTH; a++) begin
            regs_q[a] <= RESET_VAL;
         end
         busy_q <= '0;
      end else begin
         for (int a = 0; a < DEPTH; a++) begin
            regs_q[a] <= regs_d[a];
         end
         busy_q <= busy_d;
      end
   end

   // Combinational read ports with optional same-cycle write forwarding
   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_addr[k] = ra[k*ADDR_W +: ADDR_W];
         rd_val[k]  = regs_q[rd_addr[k]];
         rd_bsy[k]  = busy_q[rd_addr[k]];
`ifdef REGFILE_MP_BYPASS_EN
         if (!rst && (rd_addr[k] != '0)) begin
            if (we1 && (wa1 == rd_addr[k])) begin
               rd_val[k] = wd1;
               rd_bsy[k] = 1'b0;
            end else if (we0 && (wa0 == rd_addr[k])) begin
               rd_val[k] = wd0;
               rd_bsy[k] = 1'b0;
            end
         end
`else
`endif
         if (rd_addr[k] == '0) begin
            rd_val[k] = '0;
            rd_bsy[k] = 1'b0;
         end
         rdata[k*DATA_W +: DATA_W] = rd_val[k];
         rbusy[k]                  = rd_bsy[k];
      end
   end

   assign any_busy = |busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp : directed self-checking bench for regfile_mp (default
// parameters, NRD=2). Expected values are hand-computed constants; the
// bypass-dependent expectations follow REGFILE_MP_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NRD    = 2;

   logic                  clk;
   logic                  rst;
   logic [NRD*ADDR_W-1:0] ra;
   logic [NRD*DATA_W-1:0] rdata;
   logic [NRD-1:0]        rbusy;
   logic                  we0;
   logic [ADDR_W-1:0]     wa0;
   logic [DATA_W-1:0]     wd0;
   logic                  we1;
   logic [ADDR_W-1:0]     wa1;
   logic [DATA_W-1:0]     wd1;
   logic                  bset;
   logic [ADDR_W-1:0]     bsa;
   logic                  any_busy;

   int checks   = 0;
   int failures = 0;

   regfile_mp #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NRD(NRD),
      .RESET_VAL(32'h0000_0001)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ra(ra),
      .rdata(rdata),
      .rbusy(rbusy),
      .we0(we0),
      .wa0(wa0),
      .wd0(wd0),
      .we1(we1),
      .wa1(wa1),
      .wd1(wd1),
      .bset(bset),
      .bsa(bsa),
      .any_busy(any_busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value is wrong
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive write/scoreboard inputs just after a falling edge
   task automatic applyStimulus(input logic i_we0, input logic [ADDR_W-1:0] i_wa0,
                                input logic [DATA_W-1:0] i_wd0,
                                input logic i_we1, input logic [ADDR_W-1:0] i_wa1,
                                input logic [DATA_W-1:0] i_wd1,
                                input logic i_bset, input logic [ADDR_W-1:0] i_bsa);
      @(negedge clk);
      we0  = i_we0;  wa0 = i_wa0; wd0 = i_wd0;
      we1  = i_we1;  wa1 = i_wa1; wd1 = i_wd1;
      bset = i_bset; bsa = i_bsa;
   endtask

   // Return all write and scoreboard controls to idle
   task automatic idleInputs();
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      bset = 1'b0; bsa = '0;
   endtask

   // Let one rising edge happen, then idle the controls before reading
   task automatic stepCycle();
      @(posedge clk);
      #1;
      idleInputs();
      #1;
   endtask

   // Set both read addresses and let the combinational outputs settle
   task automatic setReads(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
      ra = {a1, a0};
      #1;
   endtask

   function automatic logic [31:0] rd0();
      return rdata[0 +: DATA_W];
   endfunction

   function automatic logic [31:0] rd1();
      return rdata[DATA_W +: DATA_W];
   endfunction

   logic [31:0] exp_val;

   // Directed test sequence
   initial begin
      rst = 1'b1;
      ra  = '0;
      idleInputs();
      #2;

      // Outputs must show reset values while rst is still high
      setReads(5'd0, 5'd1);
      checkOutput("in_reset_r0", rd0(), 32'h0000_0000);
      checkOutput("in_reset_r1", rd1(), 32'h0000_0001);

      @(negedge clk);
      rst = 1'b0;
      #1;

      // Every address after reset, both ports swept in opposite order
      for (int a = 0; a < 32; a++) begin
         setReads(ADDR_W'(a), ADDR_W'(31 - a));
         exp_val = (a == 0) ? 32'h0 : 32'h1;
         checkOutput($sformatf("reset_p0_r%0d", a), rd0(), exp_val);
         exp_val = (a == 31) ? 32'h0 : 32'h1;
         checkOutput($sformatf("reset_p1_r%0d", 31 - a), rd1(), exp_val);
         checkOutput($sformatf("reset_rbusy_%0d", a), {30'd0, rbusy}, 32'h0);
      end
      checkOutput("reset_any_busy", {31'd0, any_busy}, 32'h0);

      // Single write on port 0
      applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      stepCycle();
      setReads(5'd5, 5'd6);
      checkOutput("wr0_r5", rd0(), 32'hDEAD_BEEF);
      checkOutput("wr0_r6_untouched", rd1(), 32'h0000_0001);

      // Write to register 0 is ignored
      applyStimulus(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      stepCycle();
      setReads(5'd0, 5'd5);
      checkOutput("wr_r0_ignored", rd0(), 32'h0000_0000);
      checkOutput("wr_r0_r5_kept", rd1(), 32'hDEAD_BEEF);

      // Single write on port 1
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h1357_9BDF, 1'b0, 5'd0);
      stepCycle();
      setReads(5'd20, 5'd0);
      checkOutput("wr1_r20", rd0(), 32'h1357_9BDF);

      // Both ports to the same address: port 1 wins
      applyStimulus(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd7, 32'h5555_FFFF, 1'b0, 5'd0);
      stepCycle();
      setReads(5'd7, 5'd8);
      checkOutput("collide_r7", rd0(), 32'h5555_FFFF);
      checkOutput("collide_r8_untouched", rd1(), 32'h0000_0001);

      // Both ports to different addresses: both land
      applyStimulus(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd8, 32'h5555_FFFF, 1'b0, 5'd0);
      stepCycle();
      setReads(5'd7, 5'd8);
      checkOutput("dual_r7", rd0(), 32'hAAAA_0000);
      checkOutput("dual_r8", rd1(), 32'h5555_FFFF);

      // Scoreboard set to register 0 is ignored
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
      stepCycle();
      checkOutput("bset_r0_any_busy", {31'd0, any_busy}, 32'h0);

      // Mark register 9 pending
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
      stepCycle();
      setReads(5'd8, 5'd9);
      checkOutput("bset9_rbusy", {30'd0, rbusy}, 32'h2);
      checkOutput("bset9_any_busy", {31'd0, any_busy}, 32'h1);

      // Writeback and re-issue together: stays busy, data still lands
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999_0001, 1'b1, 5'd9);
      stepCycle();
      setReads(5'd9, 5'd9);
      checkOutput("set_beats_clr_rbusy", {30'd0, rbusy}, 32'h3);
      checkOutput("set_beats_clr_data", rd0(), 32'h9999_0001);

      // Writeback alone clears it
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999_0002, 1'b0, 5'd0);
      stepCycle();
      setReads(5'd9, 5'd9);
      checkOutput("clr9_rbusy", {30'd0, rbusy}, 32'h0);
      checkOutput("clr9_any_busy", {31'd0, any_busy}, 32'h0);
      checkOutput("clr9_data", rd1(), 32'h9999_0002);

      // Port 0 writeback clears a busy bit too
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd11);
      stepCycle();
      setReads(5'd11, 5'd0);
      checkOutput("bset11_rbusy", {30'd0, rbusy}, 32'h1);
      applyStimulus(1'b1, 5'd11, 32'h0000_0B0B, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      stepCycle();
      checkOutput("clr11_rbusy", {30'd0, rbusy}, 32'h0);
      checkOutput("clr11_any_busy", {31'd0, any_busy}, 32'h0);

      // Prepare asynchronous reset case: r3 modified, r4 busy
      applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
      stepCycle();
      setReads(5'd3, 5'd4);
      checkOutput("pre_rst_r3", rd0(), 32'h0000_0033);
      checkOutput("pre_rst_rbusy4", {30'd0, rbusy}, 32'h2);

      // Reset between edges while a write is pending
      applyStimulus(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_r3", rd0(), 32'h0000_0001);
      checkOutput("async_rst_rbusy4", {30'd0, rbusy}, 32'h0);
      checkOutput("async_rst_any_busy", {31'd0, any_busy}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("rst_edge_no_write_r3", rd0(), 32'h0000_0001);
      @(negedge clk);
      idleInputs();
      rst = 1'b0;
      setReads(5'd5, 5'd3);
      checkOutput("post_rst_r5", rd0(), 32'h0000_0001);
      checkOutput("post_rst_r3", rd1(), 32'h0000_0001);

      // Read during write on port 0
      applyStimulus(1'b1, 5'd10, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      setReads(5'd10, 5'd0);
`ifdef REGFILE_MP_BYPASS_EN
      exp_val = 32'hCAFE_F00D;
`else
      exp_val = 32'h0000_0001;
`endif
      checkOutput("rdw_before_edge", rd0(), exp_val);
      stepCycle();
      checkOutput("rdw_after_edge", rd0(), 32'hCAFE_F00D);

      // Read during write with both ports targeting the same register
      applyStimulus(1'b1, 5'd12, 32'h0000_000A, 1'b1, 5'd12, 32'h0000_000B, 1'b0, 5'd0);
      setReads(5'd0, 5'd12);
`ifdef REGFILE_MP_BYPASS_EN
      exp_val = 32'h0000_000B;
`else
      exp_val = 32'h0000_0001;
`endif
      checkOutput("rdw_dual_before_edge", rd1(), exp_val);
      stepCycle();
      checkOutput("rdw_dual_after_edge", rd1(), 32'h0000_000B);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
